// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin arbiter for 32 bus-drive requests.
// Produces a registered one-hot grant for the downstream 32-to-5 bus select
// encoder. A grant is held until the holder releases the bus or withdraws
// its request. The next winner is then picked starting just above the old
// holder, with no idle cycle in between.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, a hold counter
// forcibly ends any grant held for HOLD_MAX cycles and pulses timeout_o.
// release_i carries the "release" input; that name is reserved in SystemVerilog.
module bus_grant_arbiter #(
  parameter int N = 32
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int HOLD_MAX = 8
`endif
) (
  input  logic         clock_i,
  input  logic         clear_n_i,
  input  logic [N-1:0] req_i,
  input  logic         release_i,
  output logic [N-1:0] grant_o,
  output logic         grant_valid_o,
  output logic         timeout_o
);

  localparam int PW = $clog2(N);

`ifdef BUS_TIMEOUT_EN
  // Last count value before the forced end (the count starts at 0 on each new grant)
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
`endif

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            grant_valid_q, grant_valid_d;
  logic            timeout_q, timeout_d;
  logic [PW-1:0]   ptr_q, ptr_d;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]      hold_q, hold_d;
  logic            expire_s;
`endif

  logic [PW-1:0]   holder_s;
  logic [PW-1:0]   next_ptr_s;
  logic            grant_legal_s;
  logic            normal_end_s;
  logic            forced_end_s;
  logic            end_s;

  // First set request bit scanning upward from ptr, wrapping from N-1 to 0
  function automatic logic [PW-1:0] pick_winner(input logic [N-1:0] r,
                                                input logic [PW-1:0] p);
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;
    win   = p;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'(p + PW'(i));
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Index of a one-hot word; only meaningful when the word is legal one-hot
  function automatic logic [PW-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) begin
        idx = idx | PW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // One-hot word with only bit idx set
  function automatic logic [N-1:0] idx_to_onehot(input logic [PW-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // Non-zero word with a single bit set
  function automatic logic is_onehot(input logic [N-1:0] w);
    return (w != '0) && ((w & (w - {{(N-1){1'b0}}, 1'b1})) == '0);
  endfunction

  // Decode the holder and the grant-end conditions from the current grant
  always_comb begin
    holder_s      = onehot_to_idx(grant_q);
    next_ptr_s    = PW'(holder_s + {{(PW-1){1'b0}}, 1'b1});
    grant_legal_s = is_onehot(grant_q);
    normal_end_s  = release_i | ~req_i[holder_s];
`ifdef BUS_TIMEOUT_EN
    expire_s      = (hold_q == HOLD_LAST);
    forced_end_s  = expire_s & ~normal_end_s;
`else
    forced_end_s  = 1'b0;
`endif
    end_s         = normal_end_s | forced_end_s;
  end

  // Next-state and next-output logic for the IDLE/GRANTED controller
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i != '0) begin
          grant_d = idx_to_onehot(pick_winner(req_i, ptr_q));
          state_d = GRANTED;
`ifdef BUS_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      GRANTED: begin
        if (!grant_legal_s) begin
          // A corrupted grant word is never passed on to the encoder
          grant_d = '0;
          state_d = IDLE;
        end else if (end_s) begin
          ptr_d     = next_ptr_s;
          timeout_d = forced_end_s;
          if (req_i != '0) begin
            grant_d = idx_to_onehot(pick_winner(req_i, next_ptr_s));
            state_d = GRANTED;
`ifdef BUS_TIMEOUT_EN
            hold_d  = 8'd0;
`endif
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else begin
          grant_d = grant_q;
          state_d = GRANTED;
`ifdef BUS_TIMEOUT_EN
          hold_d  = hold_q + 8'd1;
`endif
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    grant_valid_d = (grant_d != '0);
  end

  // State, pointer and output registers; reset drops any grant at once
  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
`ifdef BUS_TIMEOUT_EN
      hold_q        <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
`ifdef BUS_TIMEOUT_EN
      hold_q        <= hold_d;
`endif
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed self-checking bench for bus_grant_arbiter.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_bus_grant_arbiter;

  logic        clock;
  logic        clear_n;
  logic [31:0] req;
  logic        rel;
  logic [31:0] grant;
  logic        grant_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  bus_grant_arbiter dut (
    .clock_i       (clock),
    .clear_n_i     (clear_n),
    .req_i         (req),
    .release_i     (rel),
    .grant_o       (grant),
    .grant_valid_o (grant_valid),
    .timeout_o     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_n = 1'b0;
    req     = 32'h0000_0000;
    rel     = 1'b0;
    repeat (2) tick();
    check("rst_grant", grant, 32'h0000_0000);
    check("rst_valid", {31'd0, grant_valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);

    // first grant after reset
    clear_n = 1'b1;
    req     = 32'h0000_0010;
    tick();
    check("first_grant", grant, 32'h0000_0010);
    check("first_valid", {31'd0, grant_valid}, 32'd1);

    // asynchronous reset in the middle of a grant
    #3;
    clear_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 32'h0000_0000);
    check("async_rst_valid", {31'd0, grant_valid}, 32'd0);
    tick();
    clear_n = 1'b1;
    tick();
    check("post_rst_grant", grant, 32'h0000_0010);

    // withdrawal -> idle, ptr becomes 5
    req = 32'h0000_0000;
    tick();
    check("withdraw_idle", grant, 32'h0000_0000);
    check("withdraw_valid", {31'd0, grant_valid}, 32'd0);

    // round-robin between bits 0 and 2
    req = 32'h0000_0005;
    tick();
    check("rr_0", grant, 32'h0000_0001);
    rel = 1'b1;
    tick();
    check("rr_1", grant, 32'h0000_0004);
    tick();
    check("rr_2", grant, 32'h0000_0001);
    tick();
    check("rr_3", grant, 32'h0000_0004);
    check("rr_valid", {31'd0, grant_valid}, 32'd1);
    rel = 1'b0;
    req = 32'h0000_0000;
    tick();
    check("rr_idle", grant, 32'h0000_0000);

    // wrap-around: ptr to 31 through a grant of bit 30
    req = 32'h4000_0000;
    tick();
    check("wrap_30", grant, 32'h4000_0000);
    req = 32'h8000_0001;
    rel = 1'b1;
    tick();
    check("wrap_31", grant, 32'h8000_0000);
    tick();
    check("wrap_0", grant, 32'h0000_0001);
    rel = 1'b0;
    req = 32'h0000_0000;
    tick();
    check("wrap_idle", {31'd0, grant_valid}, 32'd0);

    // stability while others request, then withdrawal with no idle cycle
    req = 32'h0000_0100;
    tick();
    check("stab_8", grant, 32'h0000_0100);
    req = 32'h0000_0102;
    tick();
    check("stab_hold_a", grant, 32'h0000_0100);
    tick();
    check("stab_hold_b", grant, 32'h0000_0100);
    req = 32'h0000_0002;
    tick();
    check("stab_b2b", grant, 32'h0000_0002);
    check("stab_b2b_valid", {31'd0, grant_valid}, 32'd1);
    req = 32'h0000_0000;
    tick();
    check("stab_idle", grant, 32'h0000_0000);

    // single requester with release pulses keeps the bus
    req = 32'h0000_0008;
    tick();
    check("single_0", grant, 32'h0000_0008);
    rel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_grant", grant, 32'h0000_0008);
      check("single_valid", {31'd0, grant_valid}, 32'd1);
    end
    rel = 1'b0;
    tick();
    check("single_after", grant, 32'h0000_0008);
    req = 32'h0000_0000;
    tick();
    check("single_idle", grant, 32'h0000_0000);

    // release while idle must not move ptr (ptr stays 4)
    rel = 1'b1;
    tick();
    check("idle_rel", grant, 32'h0000_0000);
    rel = 1'b0;
    req = 32'h0000_0021;
    tick();
    check("idle_rel_ptr", grant, 32'h0000_0020);
    req = 32'h0000_0000;
    tick();
    check("ptr6_idle", grant, 32'h0000_0000);

    // hold without release (ptr 6 -> winner bit 0)
    req = 32'h0000_0003;
    tick();
    check("to_start", grant, 32'h0000_0001);
`ifdef BUS_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_hold", grant, 32'h0000_0001);
      check("to_hold_pulse", {31'd0, timeout}, 32'd0);
    end
    tick();
    check("to_switch", grant, 32'h0000_0002);
    check("to_pulse", {31'd0, timeout}, 32'd1);
    tick();
    check("to_pulse_end", {31'd0, timeout}, 32'd0);
    check("to_next_hold", grant, 32'h0000_0002);
`else
    for (int i = 0; i < 110; i++) begin
      tick();
      check("no_to_hold", grant, 32'h0000_0001);
    end
    check("no_to_pulse", {31'd0, timeout}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
